// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker: FSM state encoding,
// default expected ID/timestamp and the waitrequest stall-counter width.
package sysid_checker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WAIT_ID,
      RD_TS,
      WAIT_TS,
      CHECK,
      DONE
   } state_t;

   localparam logic [31:0] EXP_ID_DEFAULT        = 32'd0;
   localparam logic [31:0] EXP_TIMESTAMP_DEFAULT = 32'd1537788542;
   localparam int          STALL_W               = 8;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read channel between the checker (master) and the system-ID slave.
interface sysid_checker_if;

   logic        m_address;
   logic        m_read;
   logic        m_waitrequest;
   logic [31:0] m_readdata;

   modport master (
      output m_address,
      output m_read,
      input  m_waitrequest,
      input  m_readdata
   );

   modport slave (
      input  m_address,
      input  m_read,
      output m_waitrequest,
      output m_readdata
   );

endinterface

// File: rtl/sysid_read_engine.sv
// Single Avalon-MM read: holds the request through waitrequest, waits out the
// fixed read latency, flags the capture cycle and aborts on a stall timeout.
module sysid_read_engine
   import sysid_checker_pkg::*;
#(
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            launch,
   input  logic            launch_addr,
   sysid_checker_if.master bus,
   output logic            accept,
   output logic            cap_valid,
   output logic            tmo,
   output logic [31:0]     cap_data
);

   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]         LAT_LAST   = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

   logic               read_q;
   logic               addr_q;
   logic               waiting;
   logic [STALL_W-1:0] stall_cnt;
   logic [1:0]         lat_cnt;

   assign bus.m_read    = read_q;
   assign bus.m_address = addr_q;

   assign accept    = read_q && !bus.m_waitrequest;
   assign tmo       = read_q && bus.m_waitrequest && (stall_cnt == STALL_LAST);
   assign cap_valid = (READ_LATENCY == 0) ? accept : (waiting && (lat_cnt == LAT_LAST));
   assign cap_data  = bus.m_readdata;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; reset is synchronous and has priority over launch.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_q    <= 1'b0;
         addr_q    <= 1'b0;
         waiting   <= 1'b0;
         stall_cnt <= '0;
         lat_cnt   <= '0;
      end else if (launch) begin
         read_q    <= 1'b1;
         addr_q    <= launch_addr;
         waiting   <= 1'b0;
         stall_cnt <= '0;
      end else if (read_q) begin
         if (bus.m_waitrequest) begin
            if (tmo) read_q <= 1'b0;
            else     stall_cnt <= stall_cnt + 1'b1;
         end else begin
            read_q  <= 1'b0;
            waiting <= (READ_LATENCY != 0);
            lat_cnt <= '0;
         end
      end else if (waiting) begin
         if (lat_cnt == LAT_LAST) waiting <= 1'b0;
         else                     lat_cnt <= lat_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sysid_checker.sv
// Reads system ID (word 0) and build timestamp (word 1), compares them with the
// expected values and reports pass/mismatch/timeout. Optional macro
// SYSID_CHECKER_AUTOSTART_EN runs one check automatically after reset release.
module sysid_checker
   import sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXP_ID         = EXP_ID_DEFAULT,
   parameter logic [31:0] EXP_TIMESTAMP  = EXP_TIMESTAMP_DEFAULT,
   parameter int          READ_LATENCY   = 0,
   parameter int          TIMEOUT_CYCLES = 15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   sysid_checker_if.master bus,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            id_mismatch,
   output logic            ts_mismatch,
   output logic            timeout,
   output logic [31:0]     id_value,
   output logic [31:0]     ts_value
);

   state_t      state;
   logic        start_req;
   logic        launch;
   logic        launch_addr;
   logic        accept;
   logic        cap_valid;
   logic        tmo;
   logic [31:0] cap_data;

`ifdef SYSID_CHECKER_AUTOSTART_EN
   // High in the first cycle after reset is released, acting as one start.
   logic auto_q;
   always_ff @(posedge clock) auto_q <= reset;
   assign start_req = start | auto_q;
`else
   assign start_req = start;
`endif

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a value held and no latch is inferred.
   always_comb begin
      launch      = 1'b0;
      launch_addr = 1'b0;
      case (state)
         IDLE:           launch = start_req;
         RD_ID, WAIT_ID: begin
            launch      = cap_valid;
            launch_addr = 1'b1;
         end
         default: ;
      endcase
   end

   sysid_read_engine #(
      .READ_LATENCY  (READ_LATENCY),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_engine (
      .clock      (clock),
      .reset      (reset),
      .launch     (launch),
      .launch_addr(launch_addr),
      .bus        (bus),
      .accept     (accept),
      .cap_valid  (cap_valid),
      .tmo        (tmo),
      .cap_data   (cap_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         // NOTE: the captured words are plain registers, not a memory, so they
         // are reset along with the flags to give a defined readback.
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         id_mismatch <= 1'b0;
         ts_mismatch <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start_req) begin
               pass        <= 1'b0;
               id_mismatch <= 1'b0;
               ts_mismatch <= 1'b0;
               timeout     <= 1'b0;
               busy        <= 1'b1;
               state       <= RD_ID;
            end
            RD_ID: begin
               if (tmo) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= DONE;
               end else if (cap_valid) begin
                  id_value <= cap_data;
                  state    <= RD_TS;
               end else if (accept) begin
                  state <= WAIT_ID;
               end
            end
            WAIT_ID: if (cap_valid) begin
               id_value <= cap_data;
               state    <= RD_TS;
            end
            RD_TS: begin
               if (tmo) begin
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= DONE;
               end else if (cap_valid) begin
                  ts_value <= cap_data;
                  state    <= CHECK;
               end else if (accept) begin
                  state <= WAIT_TS;
               end
            end
            WAIT_TS: if (cap_valid) begin
               ts_value <= cap_data;
               state    <= CHECK;
            end
            CHECK: begin
               id_mismatch <= (id_value != EXP_ID);
               ts_mismatch <= (ts_value != EXP_TIMESTAMP);
               pass        <= (id_value == EXP_ID) && (ts_value == EXP_TIMESTAMP);
               done        <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench: instance 0 uses READ_LATENCY=0, instance 1 READ_LATENCY=2;
// each has a behavioural system-ID slave with programmable stalls and data.
module tb_sysid_checker;

   localparam logic [31:0] EXP_ID_TB = 32'd0;
   localparam logic [31:0] EXP_TS_TB = 32'd1537788542;
   localparam int          TMO_TB    = 15;

   typedef struct {
      int          g;
      int          cyc;
      logic        pass;
      logic        idm;
      logic        tsm;
      logic        tmo;
      logic [31:0] idv;
      logic [31:0] tsv;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]  rst_r, start_r, hold_wait;
   logic [1:0]  busy_w, done_w, pass_w, idm_w, tsm_w, tmo_w, rd_w, addr_w;
   logic [31:0] idv_w [2];
   logic [31:0] tsv_w [2];
   logic [31:0] mem [2][2];
   int          stall_req [2][2];
   logic [31:0] last_id [2];
   logic [31:0] last_ts [2];
   exp_t        sb [$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   always @(posedge clock) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int LAT = (g == 0) ? 0 : 2;
      sysid_checker_if bus ();
      int         wait_cnt = 0;
      int         rd1_cnt  = 0;
      logic [1:0] pv = 2'b00;
      logic       pa0 = 1'b0;
      logic       pa1 = 1'b0;

      sysid_checker #(
         .READ_LATENCY  (LAT),
         .TIMEOUT_CYCLES(TMO_TB)
      ) dut (
         .clock      (clock),
         .reset      (rst_r[g]),
         .start      (start_r[g]),
         .bus        (bus),
         .busy       (busy_w[g]),
         .done       (done_w[g]),
         .pass       (pass_w[g]),
         .id_mismatch(idm_w[g]),
         .ts_mismatch(tsm_w[g]),
         .timeout    (tmo_w[g]),
         .id_value   (idv_w[g]),
         .ts_value   (tsv_w[g])
      );

      always @(posedge clock) begin
         wait_cnt <= (bus.m_read && bus.m_waitrequest) ? wait_cnt + 1 : 0;
         pv       <= {pv[0], bus.m_read && !bus.m_waitrequest};
         pa0      <= bus.m_address;
         pa1      <= pa0;
         if (bus.m_read && bus.m_address) rd1_cnt <= rd1_cnt + 1;
      end

      assign bus.m_waitrequest = bus.m_read && (hold_wait[g] || (wait_cnt < stall_req[g][bus.m_address]));
      assign rd_w[g]   = bus.m_read;
      assign addr_w[g] = bus.m_address;

      // Data is only valid in the cycle the master should capture it.
      if (LAT == 0) begin : l0
         assign bus.m_readdata = (bus.m_read && !bus.m_waitrequest) ? mem[g][bus.m_address] : 32'hDEAD_BEEF;
      end else begin : l2
         assign bus.m_readdata = pv[1] ? mem[g][pa1] : 32'hDEAD_BEEF;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic push_expect(input int g, input int stalls, input bit tmo);
      exp_t e;
      int   lat = (g == 0) ? 0 : 2;
      e.g   = g;
      e.tmo = tmo;
      if (tmo) begin
         e.cyc  = cyc + TMO_TB + 1;
         e.pass = 1'b0;
         e.idm  = 1'b0;
         e.tsm  = 1'b0;
         e.idv  = last_id[g];
         e.tsv  = last_ts[g];
      end else begin
         e.cyc  = cyc + 4 + 2 * lat + stalls;
         e.idv  = mem[g][0];
         e.tsv  = mem[g][1];
         e.idm  = (e.idv != EXP_ID_TB);
         e.tsm  = (e.tsv != EXP_TS_TB);
         e.pass = !e.idm && !e.tsm;
         last_id[g] = e.idv;
         last_ts[g] = e.tsv;
      end
      sb.push_back(e);
   endtask

   task automatic run_start(input int g, input int stalls, input bit tmo);
      push_expect(g, stalls, tmo);
      start_r[g] = 1'b1;
      tick();
      start_r[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      exp_t e;
      bit   seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (done_w[g]) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_dut",      g,         e.g);
               check("done_cycle",  cyc,       e.cyc);
               check("pass",        pass_w[g], e.pass);
               check("id_mismatch", idm_w[g],  e.idm);
               check("ts_mismatch", tsm_w[g],  e.tsm);
               check("timeout",     tmo_w[g],  e.tmo);
               check("id_value",    idv_w[g],  e.idv);
               check("ts_value",    tsv_w[g],  e.tsv);
            end
         end else begin
            tick();
         end
      end
      if (!seen) begin
         check("done_seen", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic quiet(input int n);
      int cnt = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (done_w != 2'b00) cnt++;
      end
      check("no_extra_done", cnt, 0);
   endtask

   initial begin
      int s;
      int r1;
      rst_r     = 2'b11;
      start_r   = 2'b00;
      hold_wait = 2'b00;
      for (int g = 0; g < 2; g++) begin
         mem[g][0]       = EXP_ID_TB;
         mem[g][1]       = EXP_TS_TB;
         stall_req[g][0] = 0;
         stall_req[g][1] = 0;
         last_id[g]      = '0;
         last_ts[g]      = '0;
      end
      repeat (3) tick();

      check("rst_m_read",    rd_w[0],   0);
      check("rst_m_address", addr_w[0], 0);
      check("rst_busy",      busy_w[0], 0);
      check("rst_done",      done_w[0], 0);
      check("rst_pass",      pass_w[0], 0);
      check("rst_id_mism",   idm_w[0],  0);
      check("rst_ts_mism",   tsm_w[0],  0);
      check("rst_timeout",   tmo_w[0],  0);
      check("rst_id_value",  idv_w[0],  0);
      check("rst_ts_value",  tsv_w[0],  0);

      rst_r = 2'b00;
`ifdef SYSID_CHECKER_AUTOSTART_EN
      push_expect(0, 0, 1'b0);
      push_expect(1, 0, 1'b0);
      wait_done(0);
      wait_done(1);
`endif
      quiet(10);

      // Zero-wait read of matching words; a second start mid-run is ignored.
      run_start(0, 0, 1'b0);
      check("busy_after_start", busy_w[0], 1);
      tick();
      start_r[0] = 1'b1;
      tick();
      start_r[0] = 1'b0;
      wait_done(0);
      quiet(8);
      check("busy_idle", busy_w[0], 0);

      // Timestamp mismatch.
      mem[0][1] = 32'h1234_5678;
      run_start(0, 0, 1'b0);
      wait_done(0);
      quiet(2);
      mem[0][1] = EXP_TS_TB;

      // Latency 2 with three stalls on word 0, then a wrong ID with stalls on word 1.
      stall_req[1][0] = 3;
      run_start(1, 3, 1'b0);
      wait_done(1);
      quiet(2);
      stall_req[1][0] = 0;
      stall_req[1][1] = 2;
      mem[1][0] = 32'hCAFE_0001;
      run_start(1, 2, 1'b0);
      wait_done(1);
      quiet(2);
      stall_req[1][1] = 0;

      // Waitrequest stuck high: the ID read times out and word 1 is never read.
      hold_wait[0] = 1'b1;
      r1 = u[0].rd1_cnt;
      s  = cyc;
      run_start(0, 0, 1'b1);
      for (int i = 0; i < 40 && cyc < s + TMO_TB; i++) tick();
      check("tmo_read_held", rd_w[0], 1);
      wait_done(0);
      check("tmo_read_drop", rd_w[0], 0);
      check("tmo_no_word1",  u[0].rd1_cnt, r1);
      hold_wait[0] = 1'b0;
      quiet(2);

      // Reset while stalled in the timestamp read, then a clean check.
      stall_req[0][1] = 5;
      start_r[0] = 1'b1;
      tick();
      start_r[0] = 1'b0;
      tick();
      check("rd_ts_addr", addr_w[0], 1);
      check("rd_ts_read", rd_w[0],   1);
      rst_r[0] = 1'b1;
      tick();
      check("abort_read", rd_w[0],   0);
      check("abort_busy", busy_w[0], 0);
      check("abort_done", done_w[0], 0);
      stall_req[0][1] = 0;
      last_id[0] = '0;
      last_ts[0] = '0;
      rst_r[0] = 1'b0;
`ifdef SYSID_CHECKER_AUTOSTART_EN
      push_expect(0, 0, 1'b0);
      wait_done(0);
`endif
      quiet(6);
      check("post_rst_id_value", idv_w[0], last_id[0]);
      run_start(0, 0, 1'b0);
      wait_done(0);
      quiet(4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
